mc_main_ctrl: RTL and testbench

Multi-cycle main control FSM for the CO project CPU. It sequences one shared ALU, a unified instruction/data memory and the register file over 3–5 cycles per instruction. Each cycle it drives the 3-bit ALUOp consumed by ALU_Ctrl (000 = add, 001 = sub, 010 = R-type by funct), the ALU operand selects, and all write enables. Memory accesses stall on a ready handshake.

---
 rtl/mc_ctrl_pkg.sv | 56 +++++
 rtl/mc_ctrl_outdec.sv | 68 ++++++
 rtl/mc_main_ctrl.sv | 90 +++++++++
 tb/tb_mc_main_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared constants and types for the multi-cycle main control FSM.
// Opcodes, state encodings, select codes and the control word.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       src_a;
    logic [1:0] src_b;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       pc_write_cond;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// State to control-word decoder for the multi-cycle controller.
// Purely combinational; only FETCH looks at mem_ready.
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read = 1'b1;
        ctrl.src_b    = SRCB_FOUR;
        ctrl.alu_op   = ALUOP_ADD;
        ctrl.pc_src   = PCSRC_ALU;
        ctrl.ir_write = mem_ready;
        ctrl.pc_write = mem_ready;
      end
      S_DECODE: begin
        ctrl.src_b  = SRCB_IMM_SH2;
        ctrl.alu_op = ALUOP_ADD;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ctrl.src_a  = 1'b1;
        ctrl.src_b  = SRCB_IMM;
        ctrl.alu_op = ALUOP_ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.src_a  = 1'b1;
        ctrl.src_b  = SRCB_REGB;
        ctrl.alu_op = ALUOP_RTYPE;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.src_a         = 1'b1;
        ctrl.src_b         = SRCB_REGB;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_src        = PCSRC_ALUOUT;
        ctrl.pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PCSRC_JUMP;
      end
      S_ADDI_WB: ctrl.reg_write = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multi-cycle main control FSM: state register, dispatch and
// reset gating of every enable around the control-word decoder.
module mc_main_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] instr_op_i,
  input  logic       mem_ready_i,
  input  logic       zero_i,
  output logic [2:0] ALUOp_o,
  output logic       ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic       IorD_o,
  output logic       MemRead_o,
  output logic       MemWrite_o,
  output logic       IRWrite_o,
  output logic       RegWrite_o,
  output logic       RegDst_o,
  output logic       MemtoReg_o,
  output logic [1:0] PCSource_o,
  output logic       pc_en_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;
  logic   illegal;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    illegal = 1'b0;
    case (state_q)
      S_FETCH: state_d = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (instr_op_i)
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR:
        state_d = (instr_op_i == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  state_d = mem_ready_i ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: state_d = mem_ready_i ? S_FETCH : S_MEM_WRITE;
      S_R_EXEC:    state_d = S_R_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      default:     state_d = S_FETCH;
    endcase
  end

  mc_ctrl_outdec u_outdec (
    .state     (state_q),
    .mem_ready (mem_ready_i),
    .ctrl      (ctrl)
  );

  // Reset masks every side-effecting strobe so no partial write escapes.
  always_comb begin
    ALUOp_o    = ctrl.alu_op;
    ALUSrcA_o  = ctrl.src_a;
    ALUSrcB_o  = ctrl.src_b;
    IorD_o     = ctrl.iord;
    RegDst_o   = ctrl.reg_dst;
    MemtoReg_o = ctrl.mem_to_reg;
    PCSource_o = ctrl.pc_src;
    MemRead_o  = ctrl.mem_read & ~rst_i;
    MemWrite_o = ctrl.mem_write & ~rst_i;
    IRWrite_o  = ctrl.ir_write & ~rst_i;
    RegWrite_o = ctrl.reg_write & ~rst_i;
    pc_en_o    = (ctrl.pc_write | (ctrl.pc_write_cond & zero_i))
                 & ~rst_i;
    illegal_o  = illegal & ~rst_i;
    state_o    = state_q;
  end

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Scoreboard bench for mc_main_ctrl: per-cycle expected states
// queued with stimulus, control outputs checked against a model.
module tb_mc_main_ctrl;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [5:0] instr_op_i;
  logic       mem_ready_i;
  logic       zero_i;
  logic [2:0] ALUOp_o;
  logic       ALUSrcA_o;
  logic [1:0] ALUSrcB_o;
  logic       IorD_o;
  logic       MemRead_o, MemWrite_o, IRWrite_o;
  logic       RegWrite_o, RegDst_o, MemtoReg_o;
  logic [1:0] PCSource_o;
  logic       pc_en_o, illegal_o;
  logic [3:0] state_o;

  always #5 clk = ~clk;

  mc_main_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .instr_op_i  (instr_op_i),
    .mem_ready_i (mem_ready_i),
    .zero_i      (zero_i),
    .ALUOp_o     (ALUOp_o),
    .ALUSrcA_o   (ALUSrcA_o),
    .ALUSrcB_o   (ALUSrcB_o),
    .IorD_o      (IorD_o),
    .MemRead_o   (MemRead_o),
    .MemWrite_o  (MemWrite_o),
    .IRWrite_o   (IRWrite_o),
    .RegWrite_o  (RegWrite_o),
    .RegDst_o    (RegDst_o),
    .MemtoReg_o  (MemtoReg_o),
    .PCSource_o  (PCSource_o),
    .pc_en_o     (pc_en_o),
    .illegal_o   (illegal_o),
    .state_o     (state_o)
  );

  typedef struct {
    logic [3:0] st;
    logic       rdy;
    logic       z;
    logic [5:0] op;
  } ent_t;

  ent_t sb_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   n_fetch = 0;
  int   irw_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp,
               $time);
    end
  endtask

  function automatic logic [16:0] model(input logic [3:0] st,
      input logic rdy, input logic z, input logic rst,
      input logic [5:0] op);
    logic [2:0] aop;
    logic       sa, iord, mr, mw, irw, rw, rd, m2r, pce, ill;
    logic [1:0] sb, pcs;
    aop = 3'b000; sa = 0; sb = 2'b00; iord = 0; mr = 0; mw = 0;
    irw = 0; rw = 0; rd = 0; m2r = 0; pcs = 2'b00; pce = 0; ill = 0;
    case (st)
      4'd0: begin mr = 1; sb = 2'b01; irw = rdy; pce = rdy; end
      4'd1: begin
        sb = 2'b11;
        ill = !(op == 6'b000000 || op == 6'b100011 ||
                op == 6'b101011 || op == 6'b000100 ||
                op == 6'b000010 || op == 6'b001000);
      end
      4'd2, 4'd10: begin sa = 1; sb = 2'b10; end
      4'd3: begin mr = 1; iord = 1; end
      4'd4: begin rw = 1; m2r = 1; end
      4'd5: begin mw = 1; iord = 1; end
      4'd6: begin sa = 1; aop = 3'b010; end
      4'd7: begin rw = 1; rd = 1; end
      4'd8: begin sa = 1; aop = 3'b001; pcs = 2'b01; pce = z; end
      4'd9: begin pce = 1; pcs = 2'b10; end
      4'd11: rw = 1;
      default: ;
    endcase
    if (rst) begin
      mr = 0; mw = 0; irw = 0; rw = 0; pce = 0; ill = 0;
    end
    return {aop, sa, sb, iord, mr, mw, irw, rw, rd, m2r, pcs, pce, ill};
  endfunction

  function automatic logic [16:0] dut_vec();
    return {ALUOp_o, ALUSrcA_o, ALUSrcB_o, IorD_o, MemRead_o,
            MemWrite_o, IRWrite_o, RegWrite_o, RegDst_o, MemtoReg_o,
            PCSource_o, pc_en_o, illegal_o};
  endfunction

  task automatic push(input logic [3:0] st, input logic rdy,
                      input logic z, input logic [5:0] op);
    ent_t e;
    e.st = st; e.rdy = rdy; e.z = z; e.op = op;
    sb_q.push_back(e);
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push_instr(input logic [5:0] op, input int fs,
                            input int ms, input logic z,
                            input bit skip_fetch);
    if (!skip_fetch) begin
      for (int i = 0; i < fs; i++) push(4'd0, 1'b0, rnd(), op);
      push(4'd0, 1'b1, rnd(), op);
      n_fetch++;
    end
    push(4'd1, rnd(), rnd(), op);
    case (op)
      6'b000000: begin push(4'd6, rnd(), rnd(), op);
                       push(4'd7, rnd(), rnd(), op); end
      6'b100011: begin
        push(4'd2, rnd(), rnd(), op);
        for (int i = 0; i < ms; i++) push(4'd3, 1'b0, rnd(), op);
        push(4'd3, 1'b1, rnd(), op);
        push(4'd4, rnd(), rnd(), op);
      end
      6'b101011: begin
        push(4'd2, rnd(), rnd(), op);
        for (int i = 0; i < ms; i++) push(4'd5, 1'b0, rnd(), op);
        push(4'd5, 1'b1, rnd(), op);
      end
      6'b000100: push(4'd8, rnd(), z, op);
      6'b000010: push(4'd9, rnd(), rnd(), op);
      6'b001000: begin push(4'd10, rnd(), rnd(), op);
                       push(4'd11, rnd(), rnd(), op); end
      default: ;
    endcase
  endtask

  // Drive each queued cycle after the edge, compare on the falling edge.
  task automatic run();
    ent_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      mem_ready_i = e.rdy;
      zero_i      = e.z;
      instr_op_i  = e.op;
      @(negedge clk);
      check($sformatf("state_op%h", e.op), 32'(state_o), 32'(e.st));
      check($sformatf("ctrl_s%0d", e.st), 32'(dut_vec()),
            32'(model(e.st, e.rdy, e.z, 1'b0, e.op)));
      if (IRWrite_o) irw_cnt++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_i = 1'b1; mem_ready_i = 1'b1; zero_i = 1'b0;
    instr_op_i = 6'b101011;
    @(negedge clk);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_ctrl", 32'(dut_vec()),
          32'(model(4'd0, 1'b1, 1'b0, 1'b1, instr_op_i)));
    @(posedge clk);
    #1 rst_i = 1'b0;

    // sw up to MEM_WRITE, then reset in the completing cycle
    push(4'd0, 1'b1, 1'b0, 6'b101011); n_fetch++;
    push(4'd1, 1'b0, 1'b0, 6'b101011);
    push(4'd2, 1'b1, 1'b0, 6'b101011);
    run();
    mem_ready_i = 1'b1;
    #1;
    check("mw_pre_state", 32'(state_o), 32'd5);
    check("mw_pre_write", 32'(MemWrite_o), 32'd1);
    #1 rst_i = 1'b1;
    #1;
    check("rst_mid_state", 32'(state_o), 32'd0);
    check("rst_mid_mw", 32'(MemWrite_o), 32'd0);
    check("rst_mid_ctrl", 32'(dut_vec()),
          32'(model(4'd0, 1'b1, zero_i, 1'b1, instr_op_i)));
    @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("rel_irw", 32'(IRWrite_o), 32'd1);
    check("rel_ctrl", 32'(dut_vec()),
          32'(model(4'd0, 1'b1, zero_i, 1'b0, instr_op_i)));
    @(posedge clk);
    #1;
    push_instr(6'b101011, 0, 0, 1'b0, 1'b1);
    run();

    irw_cnt = 0;
    n_fetch = 0;
    push_instr(6'b000000, 0, 0, 1'b0, 1'b0);
    run();
    check("rtype_irw", 32'(irw_cnt), 32'd1);
    irw_cnt = 0;
    push_instr(6'b100011, 2, 3, 1'b0, 1'b0);
    run();
    check("lw_irw", 32'(irw_cnt), 32'd1);
    push_instr(6'b000100, 0, 0, 1'b1, 1'b0);
    push_instr(6'b000100, 0, 0, 1'b0, 1'b0);
    push_instr(6'b101011, 0, 0, 1'b0, 1'b0);
    push_instr(6'b000010, 0, 0, 1'b0, 1'b0);
    push_instr(6'b001000, 0, 0, 1'b0, 1'b0);
    push_instr(6'b111111, 0, 0, 1'b0, 1'b0);
    push_instr(6'b101011, 1, 2, 1'b1, 1'b0);
    push_instr(6'b100011, 0, 0, 1'b1, 1'b0);
    push_instr(6'b010101, 3, 0, 1'b0, 1'b0);
    push(4'd0, 1'b0, 1'b1, 6'b000000);
    run();
    check("ir_loads", 32'(irw_cnt), 32'(n_fetch - 1));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
